// File: rtl/avalon_master_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master port among NUM_REQ requesters.
// Commands pass through combinationally. A stalled winner keeps the port until
// its command is accepted. An ID FIFO steers each read response back to the
// requester that issued the read.
module avalon_master_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int MAX_PENDING = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ*32-1:0]         req_address,
  input  logic [NUM_REQ*32-1:0]         req_writedata,
  input  logic [NUM_REQ-1:0]            req_read,
  input  logic [NUM_REQ-1:0]            req_write,
  output logic [NUM_REQ-1:0]            req_waitrequest,
  output logic [31:0]                   req_readdata,
  output logic [NUM_REQ-1:0]            req_readdatavalid,
  output logic [31:0]                   m1_address,
  output logic [31:0]                   m1_writedata,
  output logic                          m1_read,
  output logic                          m1_write,
  input  logic                          m1_waitrequest,
  input  logic                          m1_readdatavalid,
  input  logic [31:0]                   m1_readdata,
  output logic [$clog2(MAX_PENDING):0]  pending_count,
  output logic                          rsp_error
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(MAX_PENDING);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PENDING);
  localparam logic [ID_W:0]    NREQ    = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]  r_ptr;
  logic             r_locked;
  logic [ID_W-1:0]  r_owner;
  logic [ID_W-1:0]  r_fifo [MAX_PENDING];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_pending_count;
  logic             r_rsp_error;

  logic               w_read_ok;
  logic [NUM_REQ-1:0] w_elig;
  logic [ID_W:0]      w_scan_sum;
  logic               w_scan_vld;
  logic [ID_W-1:0]    w_scan_idx;
  logic               w_owner_act;
  logic               w_grant_vld;
  logic [ID_W-1:0]    w_grant_idx;
  logic [NUM_REQ-1:0] w_grant_oh;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic               w_fifo_empty;
  logic [ID_W-1:0]    w_head;
  logic [ID_W-1:0]    w_ptr_next;

  // Eligibility uses the registered count, so a same-cycle pop never unmasks reads.
  assign w_read_ok   = (r_pending_count < MAX_CNT);
  assign w_elig      = req_write | (req_read & {NUM_REQ{w_read_ok}});
  assign w_owner_act = req_read[r_owner] | req_write[r_owner];

  // Find the first eligible requester scanning from r_ptr with wrap-around.
  always_comb begin
    w_scan_vld = 1'b0;
    w_scan_idx = '0;
    w_scan_sum = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scan_sum = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (w_scan_sum >= NREQ) w_scan_sum = w_scan_sum - NREQ;
      if (!w_scan_vld && w_elig[w_scan_sum[ID_W-1:0]]) begin
        w_scan_vld = 1'b1;
        w_scan_idx = w_scan_sum[ID_W-1:0];
      end
    end
  end

  // While locked only the owner may drive the port; otherwise the scan winner does.
  always_comb begin
    if (r_locked) begin
      w_grant_vld = w_elig[r_owner];
      w_grant_idx = r_owner;
    end else begin
      w_grant_vld = w_scan_vld;
      w_grant_idx = w_scan_idx;
    end
  end

  // Mux the granted requester onto m1; a write takes precedence over a read.
  always_comb begin
    m1_address   = '0;
    m1_writedata = '0;
    m1_read      = 1'b0;
    m1_write     = 1'b0;
    w_grant_oh   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_vld && (w_grant_idx == ID_W'(i))) begin
        w_grant_oh[i] = 1'b1;
        m1_address    = req_address[32*i +: 32];
        m1_writedata  = req_writedata[32*i +: 32];
        m1_write      = req_write[i];
        m1_read       = req_read[i] & ~req_write[i];
      end
    end
  end

  assign w_accept        = w_grant_vld & ~m1_waitrequest;
  assign req_waitrequest = ~(w_grant_oh & {NUM_REQ{w_accept}});
  assign w_ptr_next      = (w_grant_idx == LAST_ID) ? '0 : w_grant_idx + ID_W'(1);

  assign w_fifo_empty = (r_pending_count == '0);
  assign w_push       = w_accept & m1_read;
  assign w_pop        = m1_readdatavalid & ~w_fifo_empty;
  assign w_head       = r_fifo[r_rd_ptr];

  // Steer the response beat to the requester at the FIFO head.
  always_comb begin
    req_readdatavalid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_readdatavalid[i] = w_pop && (w_head == ID_W'(i));
    end
  end

  assign req_readdata  = m1_readdata;
  assign pending_count = r_pending_count;
  assign rsp_error     = r_rsp_error;

  // Arbitration state: round-robin pointer and stall lock.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr    <= '0;
      r_locked <= 1'b0;
      r_owner  <= '0;
    end else if (w_accept) begin
      r_locked <= 1'b0;
      r_ptr    <= w_ptr_next;
    end else if (w_grant_vld) begin
      r_locked <= 1'b1;
      r_owner  <= w_grant_idx;
    end else if (r_locked && !w_owner_act) begin
      r_locked <= 1'b0;
    end
  end

  // Outstanding-read bookkeeping and sticky unexpected-response flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_pending_count <= '0;
      r_rsp_error     <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_pending_count <= r_pending_count + CNT_W'(1);
      else if (!w_push && w_pop) r_pending_count <= r_pending_count - CNT_W'(1);
      if (m1_readdatavalid && w_fifo_empty) r_rsp_error <= 1'b1;
    end
  end

  // ID storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clock) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_grant_idx;
  end

endmodule
